// File: rtl/shervi_pkg.sv
// Shared types and constants for the SHERVI run sequencer.
package shervi_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RUN,
    DONE
  } seq_state_t;

  // Slot index width; a single-slot build still needs a one-bit address.
  function automatic int idx_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/shervi_slot_rf.sv
// Small slot register file: one synchronous write port, one combinational read port,
// asynchronous reset plus a synchronous clear of every slot.
module shervi_slot_rf #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Full address space is backed so no out-of-range guard is needed on either port.
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: every slot is reset because callers rely on reading zeros before any write.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shervi_run_sequencer.sv
// Run controller for one SHERVIModule: for each arg slot, hold the core in reset, apply the
// arg, release reset and capture the first non-zero return or flag a timeout.
module shervi_run_sequencer
  import shervi_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int NUM_VEC    = 4,
  parameter int RST_CYCLES = 5,
  parameter int TIMEOUT    = 65535,
  localparam int IDX_W     = idx_width(NUM_VEC)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              vec_we,
  input  logic [IDX_W-1:0]  vec_waddr,
  input  logic [DATA_W-1:0] vec_wdata,
  output logic              dut_reset,
  output logic [DATA_W-1:0] dut_arg,
  input  logic [DATA_W-1:0] dut_return,
  input  logic [IDX_W-1:0]  res_raddr,
  output logic [DATA_W-1:0] res_rdata,
  output logic              res_to,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    err_count
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VEC - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W:0]    err_q, err_d;
  logic [DATA_W-1:0] arg_q, arg_d;

  logic              accept_start;
  logic              ret_seen;
  logic              run_end;
  logic              last_idx;
  logic [IDX_W-1:0]  arg_raddr;
  logic [DATA_W-1:0] arg_rdata;
  logic [DATA_W-1:0] arg_load;
  logic [DATA_W:0]   res_wdata;
  logic [DATA_W:0]   res_rd;

  assign accept_start = (state_q == IDLE) && start;
  assign ret_seen     = (dut_return != '0);
  assign run_end      = (state_q == RUN) && (ret_seen || (cnt_q == RUN_LAST));
  assign last_idx     = (idx_q == IDX_LAST);

  // The arg for the next run is fetched while leaving IDLE (slot 0) or RUN (slot idx+1);
  // a write landing in the same cycle as start is forwarded so the run sees it.
  assign arg_raddr = (state_q == IDLE) ? '0 : idx_q + 1'b1;
  assign arg_load  = ((state_q == IDLE) && vec_we && (vec_waddr == '0)) ? vec_wdata : arg_rdata;

  shervi_slot_rf #(
    .W  (DATA_W),
    .AW (IDX_W)
  ) u_arg_rf (
    .CLK     (CLK),
    .reset   (reset),
    .clr_i   (1'b0),
    .we_i    (vec_we && (state_q == IDLE)),
    .waddr_i (vec_waddr),
    .wdata_i (vec_wdata),
    .raddr_i (arg_raddr),
    .rdata_o (arg_rdata)
  );

  // Result slots carry the timeout flag as an extra MSB.
  assign res_wdata = ret_seen ? {1'b0, dut_return} : {1'b1, {DATA_W{1'b0}}};

  shervi_slot_rf #(
    .W  (DATA_W + 1),
    .AW (IDX_W)
  ) u_res_rf (
    .CLK     (CLK),
    .reset   (reset),
    .clr_i   (accept_start),
    .we_i    (run_end),
    .waddr_i (idx_q),
    .wdata_i (res_wdata),
    .raddr_i (res_raddr),
    .rdata_o (res_rd)
  );

  assign {res_to, res_rdata} = res_rd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      arg_q   <= arg_d;
    end
  end

  // NOTE: each combinational process assigns defaults first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = HOLD;
      HOLD:    if (cnt_q == HOLD_LAST) state_d = RUN;
      RUN:     if (run_end) state_d = last_idx ? DONE : HOLD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    arg_d = arg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = '0;
          cnt_d = '0;
          err_d = '0;
          arg_d = arg_load;
        end
      end
      HOLD: cnt_d = (cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (run_end) begin
          cnt_d = '0;
          if (!ret_seen) err_d = err_q + 1'b1;
          if (!last_idx) begin
            idx_d = idx_q + 1'b1;
            arg_d = arg_load;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    dut_reset = (state_q != RUN);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

  assign dut_arg   = arg_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_shervi_run_sequencer.sv
// Directed bench for shervi_run_sequencer with a behavioural core stub and run-level model.
module tb_shervi_run_sequencer;

  localparam int DATA_W     = 16;
  localparam int NUM_VEC    = 2;
  localparam int RST_CYCLES = 5;
  localparam int TIMEOUT    = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              vec_we = 1'b0;
  logic [0:0]        vec_waddr = '0;
  logic [DATA_W-1:0] vec_wdata = '0;
  logic              dut_reset;
  logic [DATA_W-1:0] dut_arg;
  logic [DATA_W-1:0] dut_return;
  logic [0:0]        res_raddr = '0;
  logic [DATA_W-1:0] res_rdata;
  logic              res_to;
  logic              busy;
  logic              done;
  logic [1:0]        err_count;

  shervi_run_sequencer #(
    .DATA_W     (DATA_W),
    .NUM_VEC    (NUM_VEC),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .CLK        (clk),
    .reset      (rst),
    .start      (start),
    .vec_we     (vec_we),
    .vec_waddr  (vec_waddr),
    .vec_wdata  (vec_wdata),
    .dut_reset  (dut_reset),
    .dut_arg    (dut_arg),
    .dut_return (dut_return),
    .res_raddr  (res_raddr),
    .res_rdata  (res_rdata),
    .res_to     (res_to),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core stub: mode 0 returns 2*arg, mode 1 returns -16, mode 2 never returns;
  // the value appears stub_lat cycles after the core leaves reset.
  int stub_mode = 0;
  int stub_lat  = 20;
  int run_cyc   = 0;

  function automatic logic [DATA_W-1:0] core_f(input int mode, input logic [DATA_W-1:0] a);
    if (mode == 0) return DATA_W'(2 * a);
    if (mode == 1) return 16'hFFF0;
    return '0;
  endfunction

  always @(posedge clk) run_cyc <= dut_reset ? 0 : run_cyc + 1;

  assign dut_return = (!dut_reset && stub_mode != 2 && run_cyc >= stub_lat)
                      ? core_f(stub_mode, dut_arg) : '0;

  // Run-level model: what each slot must end up holding and how long each run lasts.
  logic [DATA_W-1:0] m_arg [NUM_VEC];

  function automatic bit model_hit();
    return (stub_mode != 2) && (stub_lat <= TIMEOUT - 1);
  endfunction

  function automatic int model_runlen();
    return model_hit() ? stub_lat + 1 : TIMEOUT;
  endfunction

  function automatic logic [DATA_W-1:0] model_res(input int i);
    return model_hit() ? core_f(stub_mode, m_arg[i]) : '0;
  endfunction

  function automatic int model_err();
    return model_hit() ? 0 : NUM_VEC;
  endfunction

  // Cycle monitor: hold length and applied arg at each run start, run length at each end.
  bit mon_en   = 1'b0;
  int hold_cnt = 0;
  int run_cnt  = 0;
  int run_idx  = 0;
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (!dut_reset) begin
        if (run_cnt == 0) begin
          check("hold_len", hold_cnt, RST_CYCLES);
          check("run_arg", dut_arg, m_arg[run_idx % NUM_VEC]);
        end
        run_cnt++;
      end else begin
        if (run_cnt > 0) begin
          check("run_len", run_cnt, model_runlen());
          run_idx++;
          run_cnt  = 0;
          hold_cnt = 0;
        end
        if (busy && !done) hold_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic mon_reset();
    hold_cnt = 0;
    run_cnt  = 0;
    run_idx  = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
  endtask

  task automatic write_arg(input int idx, input logic [DATA_W-1:0] val);
    vec_we    = 1'b1;
    vec_waddr = idx[0:0];
    vec_wdata = val;
    @(posedge clk); #1;
    vec_we    = 1'b0;
    m_arg[idx] = val;
  endtask

  task automatic pulse_start(input bit co_write, input logic [DATA_W-1:0] co_val);
    start = 1'b1;
    if (co_write) begin
      vec_we    = 1'b1;
      vec_waddr = 1'b0;
      vec_wdata = co_val;
    end
    @(posedge clk); #1;
    start  = 1'b0;
    vec_we = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < NUM_VEC; i++) begin
      res_raddr = i[0:0];
      #1;
      check({tag, "_res"}, res_rdata, model_res(i));
      check({tag, "_to"}, res_to, !model_hit());
    end
    check({tag, "_err"}, err_count, model_err());
  endtask

  task automatic run_seq(input string tag, input bit inject, input bit co_write,
                         input logic [DATA_W-1:0] co_val);
    bit in_run = 1'b0;
    mon_reset();
    pulse_start(co_write, co_val);
    if (inject) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!dut_reset) begin
          in_run = 1'b1;
          break;
        end
      end
      check({tag, "_run_reached"}, in_run, 1);
      @(posedge clk); #1;
      start     = 1'b1;
      vec_we    = 1'b1;
      vec_waddr = 1'b0;
      vec_wdata = 16'd999;
      @(posedge clk); #1;
      start  = 1'b0;
      vec_we = 1'b0;
    end
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_runs"}, run_idx, NUM_VEC);
    mon_en = 1'b0;
    check_results(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit reached = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dut_reset", dut_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_arg", dut_arg, 0);
    for (int i = 0; i < NUM_VEC; i++) begin
      res_raddr = i[0:0];
      #1;
      check("rst_res", res_rdata, 0);
      check("rst_to", res_to, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Two successful runs, f = 2*arg, L = 20.
    write_arg(0, 16'd120);
    write_arg(1, 16'd80);
    stub_mode = 0; stub_lat = 20;
    run_seq("basic", 1'b0, 1'b0, '0);
    res_raddr = 1'b0; #1;
    check("basic_lit0", res_rdata, 16'd240);
    res_raddr = 1'b1; #1;
    check("basic_lit1", res_rdata, 16'd160);

    // Core never returns: both slots time out after TIMEOUT run cycles.
    stub_mode = 2; stub_lat = 0;
    run_seq("tmo", 1'b0, 1'b0, '0);
    check("tmo_lit_err", err_count, 2);

    // Negative return; start and write during RUN must be ignored.
    stub_mode = 1; stub_lat = 3;
    run_seq("neg", 1'b1, 1'b0, '0);
    res_raddr = 1'b1; #1;
    check("neg_lit1", res_rdata, 16'hFFF0);

    // Reset asserted during the second run aborts; a fresh run then completes.
    stub_mode = 0; stub_lat = 20;
    mon_reset();
    pulse_start(1'b0, '0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (run_idx == 1 && !dut_reset) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_reached_run1", reached, 1);
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_dut_reset", dut_reset, 1);
    check("abort_busy", busy, 0);
    check("abort_err", err_count, 0);
    res_raddr = 1'b0; #1;
    check("abort_res0", res_rdata, 0);
    check("abort_arg", dut_arg, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // Arg slots were cleared by reset; reload them.
    write_arg(0, 16'd120);
    write_arg(1, 16'd80);
    run_seq("rerun", 1'b0, 1'b0, '0);
    res_raddr = 1'b0; #1;
    check("rerun_lit0", res_rdata, 16'd240);

    // Return on the last allowed RUN cycle is captured; same-cycle write+start is used.
    stub_mode = 0; stub_lat = TIMEOUT - 1;
    m_arg[0] = 16'd50;
    run_seq("edge", 1'b0, 1'b1, 16'd50);
    res_raddr = 1'b0; #1;
    check("edge_lit0", res_rdata, 16'd100);
    check("edge_lit_to0", res_to, 0);

    // One cycle later than that is a timeout.
    stub_mode = 0; stub_lat = TIMEOUT;
    run_seq("late", 1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
